ospfb_frame_sched: RTL and testbench
====================================

OSPFB_FRAME_SCHED -- requirements
Module: ospfb_frame_sched

Interface
- REQ-001 SHALL have parameter FFT_LEN, default 64: frame length in cycles (polyphase branches).
- REQ-002 SHALL have parameter DEC_FAC, default 48: new input samples consumed per frame; legal range 1 <= DEC_FAC < FFT_LEN.
- REQ-003 SHALL have parameter LVL_WID, default $clog2(FFT_LEN)+1: width of the FIFO level input.
- REQ-004 SHALL have parameter CNT_WID, default 32: width of the statistics counters.
- REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
- REQ-006 SHALL have port rstn, input, 1: asynchronous, active-low reset.
- REQ-007 SHALL have port en, input, 1: run enable.
- REQ-008 SHALL have port fifo_level, input, LVL_WID: read-side word count of the upstream CDC FIFO.
- REQ-009 SHALL have port fifo_tvalid, input, 1: FIFO output valid.
- REQ-010 SHALL have port fifo_tready, output, 1: FIFO output ready.
- REQ-011 SHALL have port ospfb_ce, output, 1: OSPFB datapath advance strobe.
- REQ-012 SHALL have port slot, output, $clog2(FFT_LEN): branch index within the current frame.
- REQ-013 SHALL have port frame_start, output, 1: one-cycle pulse marking the first cycle of a frame.
- REQ-014 SHALL have port underflow, output, 1: one-cycle pulse on a LOAD stall.
- REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
- REQ-016 SHALL implement the states IDLE, WAIT_LVL, LOAD and SHIFT.
- REQ-017 IDLE SHALL go to WAIT_LVL when en=1.
- REQ-018 WAIT_LVL SHALL go to LOAD when fifo_level >= DEC_FAC, and SHALL go to IDLE when en=0.
- REQ-019 In LOAD, fifo_tready SHALL be 1; each cycle with fifo_tvalid=1 is a handshake, which SHALL set ospfb_ce=1 and increment slot.
- REQ-020 LOAD SHALL go to SHIFT on the cycle of handshake number DEC_FAC.
- REQ-021 In LOAD, a cycle with fifo_tvalid=0 SHALL hold slot and set ospfb_ce=0; the first such cycle in a frame SHALL pulse underflow, and later stalls in the same frame SHALL NOT pulse it.
- REQ-022 In SHIFT, fifo_tready SHALL be 0, ospfb_ce SHALL be 1 and slot SHALL increment every cycle, for exactly FFT_LEN-DEC_FAC cycles.
- REQ-023 On the last SHIFT cycle, slot SHALL wrap to 0 and the next state SHALL be LOAD if en=1 and fifo_level >= DEC_FAC, WAIT_LVL if en=1 otherwise, and IDLE if en=0.
- REQ-024 frame_start SHALL be 1 on the first cycle of every LOAD entry, whether from WAIT_LVL or from SHIFT.
- REQ-025 Deasserting en mid-frame SHALL NOT truncate the frame; the frame completes and then the block returns to IDLE.
- REQ-026 fifo_tready SHALL be a registered output and SHALL be 0 outside LOAD.
- REQ-027 Back-to-back frames with the FIFO always valid SHALL give a period of exactly FFT_LEN cycles, with no bubble between SHIFT and LOAD.
- REQ-028 fifo_level SHALL be sampled only in WAIT_LVL and on the last SHIFT cycle.

Reset
- REQ-029 When rstn=0, the block SHALL immediately enter IDLE, with slot=0 and fifo_tready, ospfb_ce, frame_start, underflow and busy all 0.
- REQ-030 A reset mid-frame SHALL abandon the frame, and after reset the next frame SHALL begin at slot 0.
- REQ-031 The statistics counters SHALL reset to 0.

Configuration
- REQ-032 Macro OSPFB_SCHED_STATS_EN SHALL control the statistics feature.
- REQ-033 When OSPFB_SCHED_STATS_EN is defined, the block SHALL add output frame_count[CNT_WID], which increments on frame_start.
- REQ-034 When OSPFB_SCHED_STATS_EN is defined, the block SHALL add output underflow_count[CNT_WID], which increments on underflow.
- REQ-035 Both statistics counters SHALL saturate at all-ones.
- REQ-036 When OSPFB_SCHED_STATS_EN is undefined, the statistics ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
- REQ-037 The bench SHALL cover: defaults, en=1, level=64, tvalid=1 -> frame_start every 64 cycles; tready high for 48 cycles then low for 16; ospfb_ce high for all 64 cycles.
- REQ-038 The bench SHALL cover: level=47 held for 100 cycles, then 48 -> no tready while in WAIT_LVL; LOAD entered the cycle after level reaches 48.
- REQ-039 The bench SHALL cover: tvalid low at handshakes 10 and 20 for 3 cycles each -> underflow pulses once; the frame lasts 70 cycles; slot is frozen during the stalls.
- REQ-040 The bench SHALL cover: en dropped at slot 5 -> the frame completes through slot 63; busy falls after 59 more cycles; tready stays 0 afterwards.
- REQ-041 The bench SHALL cover: rstn pulsed low at slot 30 of a LOAD -> all outputs 0 asynchronously; the next frame starts at slot 0.
- REQ-042 The bench SHALL cover: OSPFB_SCHED_STATS_EN defined, 10 frames with 2 underflows -> frame_count=10 and underflow_count=2.

Source files
------------

// File: rtl/ospfb_frame_sched.sv
// ospfb_frame_sched: frame scheduler for an oversampled polyphase filter bank
// Each frame takes DEC_FAC new samples from the upstream FIFO (LOAD) and then
// advances the datapath for FFT_LEN-DEC_FAC cycles with no input (SHIFT).
// Ports: clk, rstn (async active-low); en run enable; fifo_level, fifo_tvalid,
//   fifo_tready upstream FIFO side; ospfb_ce, slot, frame_start datapath
//   control; underflow first-stall pulse; busy (not IDLE).
// Define OSPFB_SCHED_STATS_EN to add saturating frame_count/underflow_count.
module ospfb_frame_sched #(
  parameter int FFT_LEN = 64,
  parameter int DEC_FAC = 48,
  parameter int LVL_WID = $clog2(FFT_LEN) + 1,
  parameter int CNT_WID = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       en,
  input  logic [LVL_WID-1:0]         fifo_level,
  input  logic                       fifo_tvalid,
  output logic                       fifo_tready,
  output logic                       ospfb_ce,
  output logic [$clog2(FFT_LEN)-1:0] slot,
  output logic                       frame_start,
  output logic                       underflow,
  output logic                       busy
`ifdef OSPFB_SCHED_STATS_EN
  ,
  output logic [CNT_WID-1:0]         frame_count,
  output logic [CNT_WID-1:0]         underflow_count
`endif
);
  localparam int SW = $clog2(FFT_LEN);
  typedef enum logic [1:0] {IDLE, WAIT_LVL, LOAD, SHIFT} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic stall_q, stall_d, tready_q, fs_q;
  logic lvl_ok, last_ld, last_sh;
  assign lvl_ok  = fifo_level >= LVL_WID'(DEC_FAC);
  assign last_ld = slot_q == SW'(DEC_FAC - 1);
  assign last_sh = slot_q == SW'(FFT_LEN - 1);
  // stall_q remembers a stall in the current LOAD so underflow fires once per frame
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    stall_d   = 1'b0;
    ospfb_ce  = 1'b0;
    underflow = 1'b0;
    case (state_q)
      IDLE:     state_d = en ? WAIT_LVL : IDLE;
      WAIT_LVL: state_d = !en ? IDLE : lvl_ok ? LOAD : WAIT_LVL;
      LOAD: begin
        ospfb_ce  = fifo_tvalid;
        underflow = !fifo_tvalid && !stall_q;
        stall_d   = stall_q || !fifo_tvalid;
        slot_d    = fifo_tvalid ? slot_q + 1'b1 : slot_q;
        state_d   = fifo_tvalid && last_ld ? SHIFT : LOAD;
      end
      default: begin
        ospfb_ce = 1'b1;
        slot_d   = last_sh ? '0 : slot_q + 1'b1;
        state_d  = !last_sh ? SHIFT : !en ? IDLE : lvl_ok ? LOAD : WAIT_LVL;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      slot_q   <= '0;
      stall_q  <= 1'b0;
      tready_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      stall_q  <= stall_d;
      tready_q <= state_d == LOAD;
      fs_q     <= state_d == LOAD && state_q != LOAD;
    end
  end
  assign fifo_tready = tready_q;
  assign frame_start = fs_q;
  assign slot        = slot_q;
  assign busy        = state_q != IDLE;
`ifdef OSPFB_SCHED_STATS_EN
  logic [CNT_WID-1:0] fc_q, uc_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fc_q <= '0;
      uc_q <= '0;
    end else begin
      if (fs_q && !(&fc_q)) fc_q <= fc_q + 1'b1;
      if (underflow && !(&uc_q)) uc_q <= uc_q + 1'b1;
    end
  end
  assign frame_count     = fc_q;
  assign underflow_count = uc_q;
`endif
endmodule

// File: tb/tb_ospfb_frame_sched.sv
// tb_ospfb_frame_sched: scoreboard bench for ospfb_frame_sched with a frame-level reference model
module tb_ospfb_frame_sched;
  localparam int FFT = 64, DEC = 48, SW = 6, LW = 7;
  logic clk = 1'b0, rstn = 1'b1, en = 1'b0, fifo_tvalid = 1'b0;
  logic [LW-1:0] fifo_level = '0;
  logic fifo_tready, ospfb_ce, frame_start, underflow, busy;
  logic [SW-1:0] slot;
`ifdef OSPFB_SCHED_STATS_EN
  logic [31:0] frame_count, underflow_count;
`endif
  typedef struct packed {
    int cyc;
    logic [SW-1:0] slot;
    logic rdy, ce, fs, uf, busy;
  } rec_t;
  rec_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  ospfb_frame_sched dut (
    .clk(clk), .rstn(rstn), .en(en), .fifo_level(fifo_level),
    .fifo_tvalid(fifo_tvalid), .fifo_tready(fifo_tready), .ospfb_ce(ospfb_ce),
    .slot(slot), .frame_start(frame_start), .underflow(underflow), .busy(busy)
`ifdef OSPFB_SCHED_STATS_EN
    , .frame_count(frame_count), .underflow_count(underflow_count)
`endif
  );
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // reference model: a frame is DEC handshakes (stalls allowed) followed by FFT-DEC free-running cycles
  bit m_act, m_wait, m_first, m_stalled, p_ld;
  int m_got, m_sh;
  rec_t p_e;
  task automatic m_begin();
    m_act = 1; m_wait = 0; m_first = 1; m_stalled = 0; m_got = 0; m_sh = 0;
  endtask
  always @(posedge clk) begin
    if (!rstn) begin
      m_act = 0; m_wait = 0; m_first = 0; m_stalled = 0; m_got = 0; m_sh = 0;
    end else if (m_act) begin
      m_first = 0;
      if (m_got < DEC) begin
        if (fifo_tvalid) m_got++;
        else m_stalled = 1;
      end else if (m_sh == FFT - DEC - 1) begin
        m_act = 0; m_got = 0; m_sh = 0;
        if (en && int'(fifo_level) >= DEC) m_begin();
        else m_wait = en;
      end else m_sh++;
    end else if (m_wait) begin
      if (!en) m_wait = 0;
      else if (int'(fifo_level) >= DEC) m_begin();
    end else if (en) m_wait = 1;
  end
  always @(negedge clk) begin
    #1;
    if (m_act || m_wait) begin
      p_ld = m_act && m_got < DEC;
      p_e.cyc  = cyc;
      p_e.slot = SW'(m_got + m_sh);
      p_e.rdy  = p_ld;
      p_e.ce   = m_act && (p_ld ? fifo_tvalid : 1'b1);
      p_e.fs   = m_act && m_first;
      p_e.uf   = p_ld && !fifo_tvalid && !m_stalled;
      p_e.busy = 1'b1;
      exp_q.push_back(p_e);
    end
  end
  rec_t mon_a, mon_e;
  always @(negedge clk) begin
    #2;
    if (busy || ospfb_ce || fifo_tready || frame_start || underflow) begin
      mon_a = '{cyc, slot, fifo_tready, ospfb_ce, frame_start, underflow, busy};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: cyc=%0d slot=%0d rdy=%b ce=%b fs=%b uf=%b busy=%b, no output expected",
                 cyc, slot, fifo_tready, ospfb_ce, frame_start, underflow, busy);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL sb_cycle: got cyc=%0d slot=%0d rdy=%b ce=%b fs=%b uf=%b busy=%b expected cyc=%0d slot=%0d rdy=%b ce=%b fs=%b uf=%b busy=%b",
                   mon_a.cyc, mon_a.slot, mon_a.rdy, mon_a.ce, mon_a.fs, mon_a.uf, mon_a.busy,
                   mon_e.cyc, mon_e.slot, mon_e.rdy, mon_e.ce, mon_e.fs, mon_e.uf, mon_e.busy);
        end
      end
    end
  end
  // stimulus-side frame statistics, closed at every frame_start
  bit en_v = 0, tv_v = 0, stall_on = 0;
  logic [LW-1:0] lvl_v = '0;
  int stall_left = 0, hs = 0, nfs = 0, fs_cyc = 0;
  int c_rdy = 0, c_ce = 0, c_uf = 0, c_frz = 0;
  int p_len = 0, p_rdy = 0, p_ce = 0, p_uf = 0, p_frz = 0;
  task automatic cycle();
    @(negedge clk);
    rstn = 1'b1;
    en = en_v;
    fifo_level = lvl_v;
    fifo_tvalid = stall_left > 0 ? 1'b0 : tv_v;
    if (stall_left > 0) stall_left--;
    #2;
    if (frame_start) begin
      p_len = cyc - fs_cyc; p_rdy = c_rdy; p_ce = c_ce; p_uf = c_uf; p_frz = c_frz;
      fs_cyc = cyc; c_rdy = 0; c_ce = 0; c_uf = 0; c_frz = 0; hs = 0; nfs++;
    end
    if (fifo_tready) c_rdy++;
    if (ospfb_ce) c_ce++;
    if (underflow) c_uf++;
    if (fifo_tready && !fifo_tvalid && int'(slot) == hs) c_frz++;
    if (fifo_tready && fifo_tvalid) begin
      hs++;
      if (stall_on && (hs == 10 || hs == 20)) stall_left = 3;
    end
  endtask
  task automatic wait_fs(input string nm, output int n);
    int k = nfs;
    n = 0;
    while (nfs == k && n < 400) begin
      cycle();
      n++;
    end
    if (nfs == k) chk({nm, "_timeout"}, 0, 1);
  endtask
  task automatic wait_idle(input string nm, output int n);
    n = 0;
    cycle();
    n++;
    while (busy && n < 400) begin
      cycle();
      n++;
    end
    chk(nm, int'(busy), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
  initial begin
    int n, r, f, b, ls;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outputs", int'({fifo_tready, ospfb_ce, frame_start, underflow, busy, slot}), 0);
    cycle();
    // continuous stream: fixed 64-cycle frames
    en_v = 1; lvl_v = LW'(64); tv_v = 1;
    wait_fs("a_first", n);
    for (int i = 0; i < 3; i++) begin
      wait_fs("a_next", n);
      chk("a_period", p_len, FFT);
      chk("a_tready_cycles", p_rdy, DEC);
      chk("a_ce_cycles", p_ce, FFT);
      chk("a_underflow", p_uf, 0);
    end
    // level one short of a frame, then exactly enough
    en_v = 0;
    wait_idle("b_idle", n);
    en_v = 1; lvl_v = LW'(47);
    r = 0; f = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (fifo_tready) r++;
      if (frame_start) f++;
    end
    chk("b_no_tready", r, 0);
    chk("b_no_start", f, 0);
    chk("b_waiting_busy", int'(busy), 1);
    lvl_v = LW'(48);
    wait_fs("b_load", n);
    chk("b_load_latency", n, 2);
    chk("b_start_slot", int'(slot), 0);
    // two 3-cycle stalls in one frame
    stall_on = 1;
    wait_fs("c_next", n);
    stall_on = 0;
    chk("c_frame_len", p_len, FFT + 6);
    chk("c_underflow_pulses", p_uf, 1);
    chk("c_slot_frozen", p_frz, 6);
    chk("c_tready_cycles", p_rdy, DEC + 6);
    chk("c_ce_cycles", p_ce, FFT);
    // en dropped mid-frame
    n = 0;
    while (slot != SW'(4) && n < 100) begin
      cycle();
      n++;
    end
    en_v = 0;
    cycle();
    chk("d_slot_at_drop", int'(slot), 5);
    n = 0; ls = 0;
    do begin
      cycle();
      n++;
      if (busy) ls = int'(slot);
    end while (busy && n < 200);
    chk("d_busy_tail", n, 59);
    chk("d_last_slot", ls, FFT - 1);
    r = 0; b = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (fifo_tready) r++;
      if (busy) b++;
    end
    chk("d_tready_after", r, 0);
    chk("d_busy_after", b, 0);
    // asynchronous reset in the middle of LOAD
    en_v = 1; lvl_v = LW'(64); tv_v = 1;
    wait_fs("e_start", n);
    n = 0;
    while (!(slot == SW'(30) && fifo_tready) && n < 100) begin
      cycle();
      n++;
    end
    #1 rstn = 1'b0;
    #1;
    chk("e_async_reset", int'({fifo_tready, ospfb_ce, frame_start, underflow, busy, slot}), 0);
    wait_fs("e_restart", n);
    chk("e_restart_slot", int'(slot), 0);
    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) en_v = !en_v;
      if ($urandom_range(0, 15) == 0) lvl_v = LW'($urandom_range(40, 64));
      tv_v = $urandom_range(0, 3) != 0;
      cycle();
    end
`ifdef OSPFB_SCHED_STATS_EN
    // ten frames, stalls in two of them
    #1 rstn = 1'b0;
    en_v = 1; lvl_v = LW'(64); tv_v = 1;
    for (int k = 1; k <= 10; k++) begin
      wait_fs("g_frame", n);
      stall_on = k == 3 || k == 7;
    end
    stall_on = 0;
    en_v = 0;
    wait_idle("g_idle", n);
    chk("g_frame_count", int'(frame_count), 10);
    chk("g_underflow_count", int'(underflow_count), 2);
`endif
    en_v = 0;
    wait_idle("end_idle", n);
    repeat (3) cycle();
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
